// File: rtl/layer_sequencer_if.sv
// Command push bus from the CSB block and configuration/handshake bus to the engine.
// The sequencer uses the slave view; the CSB/engine side uses the master view.
interface layer_sequencer_if;
   logic        cmd_we;
   logic [2:0]  cmd_op_type;
   logic [3:0]  cmd_stride;
   logic [15:0] cmd_stride2;
   logic [7:0]  cmd_kernel;
   logic [7:0]  cmd_kernel_size;
   logic [15:0] cmd_i_channel;
   logic [15:0] cmd_o_channel;
   logic [7:0]  cmd_i_side;
   logic [7:0]  cmd_o_side;
   logic        engine_ready;
   logic        engine_valid;
   logic [2:0]  op_type;
   logic [3:0]  stride;
   logic [15:0] stride2;
   logic [7:0]  kernel;
   logic [7:0]  kernel_size;
   logic [15:0] i_channel;
   logic [15:0] o_channel;
   logic [7:0]  i_side;
   logic [7:0]  o_side;

   modport master (
      output cmd_we, cmd_op_type, cmd_stride, cmd_stride2, cmd_kernel, cmd_kernel_size,
             cmd_i_channel, cmd_o_channel, cmd_i_side, cmd_o_side, engine_ready,
      input  engine_valid, op_type, stride, stride2, kernel, kernel_size,
             i_channel, o_channel, i_side, o_side
   );

   modport slave (
      input  cmd_we, cmd_op_type, cmd_stride, cmd_stride2, cmd_kernel, cmd_kernel_size,
             cmd_i_channel, cmd_o_channel, cmd_i_side, cmd_o_side, engine_ready,
      output engine_valid, op_type, stride, stride2, kernel, kernel_size,
             i_channel, o_channel, i_side, o_side
   );
endinterface

// File: rtl/layer_sequencer.sv
// Layer descriptor FIFO plus issue FSM: pops one descriptor at a time onto the engine
// configuration bus, holds engine_valid until engine_ready, and tracks layers and errors.
module layer_sequencer #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic                clk,
   input  logic                rst,
   layer_sequencer_if.slave    bus,
   input  logic                run_en,
   input  logic                err_clr,
   output logic [CW-1:0]       cmd_count,
   output logic                cmd_full,
   output logic                seq_busy,
   output logic                seq_done,
   output logic [15:0]         layer_cnt,
   output logic                err_overflow,
   output logic                err_op
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [2:0]  op;
      logic [3:0]  stride;
      logic [15:0] stride2;
      logic [7:0]  kernel;
      logic [7:0]  ksize;
      logic [15:0] ic;
      logic [15:0] oc;
      logic [7:0]  i_side;
      logic [7:0]  o_side;
   } desc_t;

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, RELEASE} state_t;

   state_t        state, state_nxt;
   desc_t         mem [DEPTH];
   desc_t         din, head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          empty, pop, push_ok, push_drop;
   logic          head_legal, valid_nxt, cnt_inc, op_bad, done_nxt;

   assign din = '{op: bus.cmd_op_type, stride: bus.cmd_stride, stride2: bus.cmd_stride2,
                  kernel: bus.cmd_kernel, ksize: bus.cmd_kernel_size, ic: bus.cmd_i_channel,
                  oc: bus.cmd_o_channel, i_side: bus.cmd_i_side, o_side: bus.cmd_o_side};
   assign head       = mem[rd_ptr];
   assign head_legal = (head.op != 3'd0) && (head.op <= 3'd3);
   assign empty      = (cmd_count == '0);
   assign cmd_full   = (cmd_count == CW'(DEPTH));
   assign seq_busy   = (state != IDLE);
   // A full FIFO still accepts a push in the same cycle the head is popped.
   assign push_ok    = bus.cmd_we && (!cmd_full || pop);
   assign push_drop  = bus.cmd_we && !push_ok;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      valid_nxt = 1'b0;
      cnt_inc   = 1'b0;
      op_bad    = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: if (run_en && !empty) state_nxt = LOAD;
         LOAD: begin
            pop = 1'b1;
            if (head_legal) begin
               valid_nxt = 1'b1;
               state_nxt = ISSUE;
            end else begin
               op_bad    = 1'b1;
               state_nxt = RELEASE;
            end
         end
         ISSUE: begin
            if (bus.engine_ready) begin
               cnt_inc   = 1'b1;
               state_nxt = RELEASE;
            end else begin
               valid_nxt = 1'b1;
            end
         end
         RELEASE: begin
            if (run_en && !empty) begin
               state_nxt = LOAD;
            end else begin
               done_nxt  = empty;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         cmd_count        <= '0;
         bus.engine_valid <= 1'b0;
         seq_done         <= 1'b0;
         layer_cnt        <= '0;
         err_overflow     <= 1'b0;
         err_op           <= 1'b0;
      end else begin
         state            <= state_nxt;
         bus.engine_valid <= valid_nxt;
         seq_done         <= done_nxt;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   cmd_count <= cmd_count + 1'b1;
            2'b01:   cmd_count <= cmd_count - 1'b1;
            default: cmd_count <= cmd_count;
         endcase
         if (cnt_inc) layer_cnt <= layer_cnt + 1'b1;
         // Clear wins over a same-cycle set.
         if (err_clr)        err_overflow <= 1'b0;
         else if (push_drop) err_overflow <= 1'b1;
         if (err_clr)        err_op <= 1'b0;
         else if (op_bad)    err_op <= 1'b1;
      end
   end

   // Config bus only moves on the LOAD edge and otherwise keeps the last layer's values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.op_type     <= '0;
         bus.stride      <= '0;
         bus.stride2     <= '0;
         bus.kernel      <= '0;
         bus.kernel_size <= '0;
         bus.i_channel   <= '0;
         bus.o_channel   <= '0;
         bus.i_side      <= '0;
         bus.o_side      <= '0;
      end else if (pop) begin
         bus.op_type     <= head.op;
         bus.stride      <= head.stride;
         bus.stride2     <= head.stride2;
         bus.kernel      <= head.kernel;
         bus.kernel_size <= head.ksize;
         bus.i_channel   <= head.ic;
         bus.o_channel   <= head.oc;
         bus.i_side      <= head.i_side;
         bus.o_side      <= head.o_side;
      end
   end
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: single layer, back-to-back, overflow, illegal op,
// run_en hold and reset during ISSUE, all against hand-computed expectations.
module tb_layer_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        run_en;
   logic        err_clr;
   logic [2:0]  cmd_count;
   logic        cmd_full, seq_busy, seq_done, err_overflow, err_op;
   logic [15:0] layer_cnt;

   int checks   = 0;
   int failures = 0;

   logic       mon_clr;
   logic [6:0] iss_q[$];
   int         done_cnt, min_gap, low_run;
   bit         seen_hi, prev_v;

   layer_sequencer_if bus ();

   layer_sequencer #(.DEPTH(4), .CW(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .run_en       (run_en),
      .err_clr      (err_clr),
      .cmd_count    (cmd_count),
      .cmd_full     (cmd_full),
      .seq_busy     (seq_busy),
      .seq_done     (seq_done),
      .layer_cnt    (layer_cnt),
      .err_overflow (err_overflow),
      .err_op       (err_op)
   );

   always #5 clk = ~clk;

   // Records each engine_valid rise as {stride, op_type}, seq_done pulses and low gaps.
   always @(negedge clk) begin
      if (mon_clr) begin
         iss_q.delete();
         done_cnt = 0;
         min_gap  = 99;
         low_run  = 0;
         seen_hi  = 1'b0;
         prev_v   = 1'b0;
      end else begin
         if (seq_done) done_cnt++;
         if (bus.engine_valid) begin
            if (!prev_v) begin
               iss_q.push_back({bus.stride, bus.op_type});
               if (seen_hi && low_run < min_gap) min_gap = low_run;
            end
            seen_hi = 1'b1;
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_v = bus.engine_valid;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] qget(input int i);
      if (i < iss_q.size()) return iss_q[i];
      return 7'h7f;
   endfunction

   task automatic push(input logic [2:0] op, input logic [3:0] st);
      bus.cmd_we          = 1'b1;
      bus.cmd_op_type     = op;
      bus.cmd_stride      = st;
      bus.cmd_stride2     = 16'(st) * 16'd3;
      bus.cmd_kernel      = 8'd3;
      bus.cmd_kernel_size = 8'd9;
      bus.cmd_i_channel   = 16'd3;
      bus.cmd_o_channel   = 16'd1;
      bus.cmd_i_side      = 8'd5;
      bus.cmd_o_side      = 8'd3;
      tick();
      bus.cmd_we          = 1'b0;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   // Acks every issued layer two cycles after it appears, until n are served and idle.
   task automatic serve(input int n, output int served);
      int w;
      served = 0;
      w = 0;
      for (int c = 0; c < 400; c++) begin
         if (served == n && !seq_busy) break;
         if (bus.engine_valid) begin
            if (w == 2) begin
               bus.engine_ready = 1'b1;
               tick();
               bus.engine_ready = 1'b0;
               served++;
               w = 0;
            end else begin
               w++;
               tick();
            end
         end else begin
            tick();
         end
      end
      repeat (4) tick();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.engine_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int  s;
      bit  ok;
      rst = 1'b1; run_en = 1'b0; err_clr = 1'b0; mon_clr = 1'b1;
      bus.cmd_we = 1'b0; bus.engine_ready = 1'b0;
      bus.cmd_op_type = '0; bus.cmd_stride = '0; bus.cmd_stride2 = '0;
      bus.cmd_kernel = '0; bus.cmd_kernel_size = '0; bus.cmd_i_channel = '0;
      bus.cmd_o_channel = '0; bus.cmd_i_side = '0; bus.cmd_o_side = '0;
      repeat (2) tick();
      rst = 1'b0; mon_clr = 1'b0;

      check("rst_valid", 32'(bus.engine_valid), 0);
      check("rst_count", 32'(cmd_count), 0);
      check("rst_full", 32'(cmd_full), 0);
      check("rst_busy", 32'(seq_busy), 0);
      check("rst_layer", 32'(layer_cnt), 0);
      check("rst_errs", 32'({err_overflow, err_op, seq_done}), 0);
      check("rst_op", 32'(bus.op_type), 0);

      // Single CMAC layer
      run_en = 1'b1;
      push(3'd1, 4'd2);
      check("t1_count_after_push", 32'(cmd_count), 1);
      check("t1_valid_n", 32'(bus.engine_valid), 0);
      tick();
      check("t1_busy_n1", 32'(seq_busy), 1);
      check("t1_valid_n1", 32'(bus.engine_valid), 0);
      tick();
      check("t1_valid_n2", 32'(bus.engine_valid), 1);
      check("t1_op", 32'(bus.op_type), 1);
      check("t1_stride", 32'(bus.stride), 2);
      check("t1_stride2", 32'(bus.stride2), 6);
      check("t1_kernel", 32'(bus.kernel), 3);
      check("t1_ksize", 32'(bus.kernel_size), 9);
      check("t1_ic", 32'(bus.i_channel), 3);
      check("t1_oc", 32'(bus.o_channel), 1);
      check("t1_is", 32'(bus.i_side), 5);
      check("t1_os", 32'(bus.o_side), 3);
      check("t1_count_popped", 32'(cmd_count), 0);
      repeat (40) tick();
      check("t1_hold_valid", 32'(bus.engine_valid), 1);
      check("t1_hold_cfg", 32'(bus.stride2), 6);
      bus.engine_ready = 1'b1;
      tick();
      bus.engine_ready = 1'b0;
      check("t1_valid_m", 32'(bus.engine_valid), 0);
      check("t1_layer_m", 32'(layer_cnt), 1);
      check("t1_done_m", 32'(seq_done), 0);
      tick();
      check("t1_done_m1", 32'(seq_done), 1);
      check("t1_busy_m1", 32'(seq_busy), 0);
      tick();
      check("t1_done_m2", 32'(seq_done), 0);
      check("t1_done_count", 32'(done_cnt), 1);
      check("t1_cfg_retained", 32'(bus.kernel), 3);

      // Back-to-back ops 1, 2, 3
      clear_mon();
      push(3'd1, 4'd1);
      push(3'd2, 4'd1);
      push(3'd3, 4'd1);
      serve(3, s);
      check("t2_served", 32'(s), 3);
      check("t2_issues", 32'(iss_q.size()), 3);
      check("t2_op0", 32'(qget(0) & 7'h7), 1);
      check("t2_op1", 32'(qget(1) & 7'h7), 2);
      check("t2_op2", 32'(qget(2) & 7'h7), 3);
      check("t2_gap_ge2", 32'(min_gap >= 2), 1);
      check("t2_layer", 32'(layer_cnt), 4);
      check("t2_done_once", 32'(done_cnt), 1);

      // Overflow with run_en low
      run_en = 1'b0;
      for (int i = 1; i <= 5; i++) push(3'd1, 4'(i));
      check("t3_count", 32'(cmd_count), 4);
      check("t3_full", 32'(cmd_full), 1);
      check("t3_ovf", 32'(err_overflow), 1);
      check("t3_no_issue", 32'({bus.engine_valid, seq_busy}), 0);
      clear_mon();
      run_en = 1'b1;
      serve(4, s);
      check("t3_served", 32'(s), 4);
      check("t3_issues", 32'(iss_q.size()), 4);
      check("t3_st0", 32'(qget(0) >> 3), 1);
      check("t3_st1", 32'(qget(1) >> 3), 2);
      check("t3_st2", 32'(qget(2) >> 3), 3);
      check("t3_st3", 32'(qget(3) >> 3), 4);
      check("t3_layer", 32'(layer_cnt), 8);
      check("t3_count_empty", 32'(cmd_count), 0);
      check("t3_ovf_sticky", 32'(err_overflow), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t3_ovf_clr", 32'(err_overflow), 0);

      // Illegal op followed by a legal one
      clear_mon();
      push(3'd5, 4'd7);
      push(3'd1, 4'd8);
      serve(1, s);
      check("t4_err_op", 32'(err_op), 1);
      check("t4_issues", 32'(iss_q.size()), 1);
      check("t4_issue_entry", 32'(qget(0)), 32'({4'd8, 3'd1}));
      check("t4_layer", 32'(layer_cnt), 9);
      check("t4_done_once", 32'(done_cnt), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t4_err_clr", 32'(err_op), 0);

      // run_en dropped during ISSUE
      push(3'd2, 4'd9);
      push(3'd2, 4'd10);
      push(3'd2, 4'd11);
      wait_valid(ok);
      check("t5_valid_seen", 32'(ok), 1);
      run_en = 1'b0;
      repeat (3) tick();
      check("t5_no_abort", 32'(bus.engine_valid), 1);
      bus.engine_ready = 1'b1;
      tick();
      bus.engine_ready = 1'b0;
      repeat (4) tick();
      check("t5_idle", 32'(seq_busy), 0);
      check("t5_count", 32'(cmd_count), 2);
      check("t5_layer", 32'(layer_cnt), 10);
      run_en = 1'b1;
      serve(2, s);
      check("t5_resume_served", 32'(s), 2);
      check("t5_resume_layer", 32'(layer_cnt), 12);
      check("t5_resume_count", 32'(cmd_count), 0);

      // Reset during ISSUE with flags set and entries queued
      run_en = 1'b0;
      push(3'd5, 4'd1);
      for (int i = 0; i < 4; i++) push(3'd1, 4'd2);
      run_en = 1'b1;
      wait_valid(ok);
      check("t6_valid_seen", 32'(ok), 1);
      check("t6_flags_set", 32'({err_overflow, err_op}), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_en = 1'b0;
      check("t6_valid", 32'(bus.engine_valid), 0);
      check("t6_count", 32'(cmd_count), 0);
      check("t6_layer", 32'(layer_cnt), 0);
      check("t6_flags", 32'({err_overflow, err_op, seq_done, cmd_full, seq_busy}), 0);
      check("t6_cfg", 32'(bus.op_type), 0);
      bus.engine_ready = 1'b1;
      tick();
      bus.engine_ready = 1'b0;
      check("t6_ready_ignored", 32'(layer_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
